uart_tx: RTL and testbench

// - Serialises one byte per request onto the UART tx line as 8N1 (8E1 with parity): start bit, 8 data bits LSB first, [parity], 1 stop bit.
// - Transmit-side counterpart of the UART receiver: same clk_freq/baud_rate divider scheme, same idle-high line.
// - Sits between a byte-producing client (valid/ready handshake) and the pad driving the serial tx pin.

---
 rtl/uart_tx.sv | 111 +++++++++++
 tb/tb_uart_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as 8N1 on an idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1).
module uart_tx #(
  parameter int unsigned clk_freq  = 50000000,
  parameter int unsigned baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned ClkDiv  = clk_freq / baud_rate;
  localparam logic [11:0] DivLast = 12'(ClkDiv - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [11:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        cell_end;

  assign cell_end = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    div_d   = (cell_end || state_q == StIdle || state_q == StDone) ? 12'd0 : div_q + 12'd1;

    case (state_q)
      StIdle: begin
        idx_d = 3'd0;
        if (tx_valid) begin
          shift_d = tx_data_in;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cell_end) state_d = StData;
      end
      StData: begin
        if (cell_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (cell_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (cell_end) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Line level follows the next state so tx only moves on state entry or cell boundaries.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= 12'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = (state_q != StIdle);
  assign tx_done  = (state_q == StDone);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with clock_divide = 16; frame contents checked every cycle.
module tb_uart_tx;

  localparam int Cd = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NCells = 11;
`else
  localparam int NCells = 10;
`endif
  localparam int Last = Cd * NCells;  // tx_done is high in cycle Last+1 after acceptance

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b1;
  logic [7:0] tx_data_in = 8'hA5;
  logic       tx_ready, tx, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .clk_freq (16),
    .baud_rate(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data_in(tx_data_in),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level in cycle k (1-based) after the acceptance edge.
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k <= Cd) return 1'b0;
    if (k <= 9 * Cd) return b[3'((k - Cd - 1) / Cd)];
`ifdef UART_TX_PARITY_EN
    if (k <= 10 * Cd) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic idle_chk(input string tag);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_ready"}, tx_ready, 1'b1);
    check({tag, "_busy"}, tx_busy, 1'b0);
    check({tag, "_done"}, tx_done, 1'b0);
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    tx_valid   = 1'b1;
    tx_data_in = b;
    idle_chk("pre");
  endtask

  task automatic watch(input logic [7:0] b, input bit hold, input int chg_k,
                       input logic [7:0] chg_v, input int upto);
    for (int k = 1; k <= upto; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) tx_valid = 1'b0;
      if (k == chg_k) tx_data_in = chg_v;
      check("frame_tx", tx, exp_tx(k, b));
      check("frame_done", tx_done, k == Last + 1);
      check("frame_busy", tx_busy, 1'b1);
      check("frame_ready", tx_ready, 1'b0);
    end
  endtask

  initial begin
    // Reset held with a pending request: nothing may start.
    repeat (3) begin
      @(negedge clk);
      idle_chk("rst");
    end
    rst      = 1'b0;
    tx_valid = 1'b0;

    offer(8'hA5);
    watch(8'hA5, 1'b0, 0, 8'h00, Last + 1);
    @(negedge clk);
    idle_chk("a5_end");

    // Valid held: second frame accepted on the edge ending the IDLE cycle after DONE.
    offer(8'h3C);
    watch(8'h3C, 1'b1, 50, 8'hC3, Last + 1);
    @(negedge clk);
    idle_chk("b2b_gap");
    watch(8'hC3, 1'b0, 0, 8'h00, Last + 1);
    @(negedge clk);
    idle_chk("c3_end");

    offer(8'h00);
    watch(8'h00, 1'b0, 40, 8'hFF, Last + 1);
    @(negedge clk);
    idle_chk("chg_end");

    // Reset in the middle of data bit 4.
    offer(8'h55);
    watch(8'h55, 1'b0, 0, 8'h00, 88);
    rst = 1'b1;
    @(negedge clk);
    idle_chk("rst_mid");
    rst = 1'b0;
    repeat (Last) begin
      @(negedge clk);
      check("post_rst_done", tx_done, 1'b0);
      check("post_rst_tx", tx, 1'b1);
    end
    offer(8'h12);
    watch(8'h12, 1'b0, 0, 8'h00, Last + 1);
    @(negedge clk);
    idle_chk("12_end");

`ifdef UART_TX_PARITY_EN
    offer(8'h07);
    watch(8'h07, 1'b0, 0, 8'h00, Last + 1);
    @(negedge clk);
    idle_chk("p07_end");
    offer(8'h03);
    watch(8'h03, 1'b0, 0, 8'h00, Last + 1);
    @(negedge clk);
    idle_chk("p03_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
